// File: rtl/alu_operand_stage.sv
// Register file plus issue stage ahead of the ALU: reads sources with write-back bypass and registers a/b/ctrl.
// Latency 1 cycle; stall freezes the operand registers and drops the presented request (no buffering).
module alu_operand_stage #(
    parameter int N = 32,
    parameter int A = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue_valid,
    input  logic [A-1:0] rs1,
    input  logic [A-1:0] rs2,
    input  logic [2:0]   ctrl_in,
    input  logic         use_imm,
    input  logic [N-1:0] imm,
    input  logic         stall,
    input  logic         wb_en,
    input  logic [A-1:0] wb_addr,
    input  logic [N-1:0] wb_data,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [2:0]   ctrl,
    output logic         op_valid
);

    localparam int DEPTH = 2 ** A;

    logic [N-1:0] rf_q [DEPTH];
    logic [N-1:0] rd1, rd2;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]   ctrl_q, ctrl_d;
    logic         vld_q, vld_d;
    logic         wb_act;

    // Register 0 is hardwired to zero, so writes to it are dropped and never bypassed.
    assign wb_act = wb_en && (wb_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_act) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1 = rf_q[rs1];
        if (rs1 == '0) begin
            rd1 = '0;
        end else if (wb_act && (wb_addr == rs1)) begin
            rd1 = wb_data;
        end
        rd2 = rf_q[rs2];
        if (rs2 == '0) begin
            rd2 = '0;
        end else if (wb_act && (wb_addr == rs2)) begin
            rd2 = wb_data;
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        ctrl_d = ctrl_q;
        vld_d  = vld_q;
        if (!stall) begin
            vld_d = issue_valid;
            if (issue_valid) begin
                a_d    = rd1;
                b_d    = use_imm ? imm : rd2;
                ctrl_d = ctrl_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= 3'b000;
            vld_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            ctrl_q <= ctrl_d;
            vld_q  <= vld_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign ctrl     = ctrl_q;
    assign op_valid = vld_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  rs1, rs2;
    logic [2:0]  ctrl_in;
    logic        use_imm;
    logic [31:0] imm;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] a, b;
    logic [2:0]  ctrl;
    logic        op_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_a, m_b;
    logic [2:0]  m_ctrl;
    logic        m_vld;

    alu_operand_stage #(.N(32), .A(5)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
        .ctrl_in(ctrl_in), .use_imm(use_imm), .imm(imm), .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .a(a), .b(b), .ctrl(ctrl), .op_valid(op_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] src);
        if (src == 5'd0) return 32'd0;
        if (wb_en && wb_addr == src) return wb_data;
        return m_rf[src];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_a = 32'd0; m_b = 32'd0; m_ctrl = 3'b000; m_vld = 1'b0;
    endtask

    task automatic idle();
        issue_valid = 0; rs1 = 0; rs2 = 0; ctrl_in = 0; use_imm = 0; imm = 0;
        stall = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    // One clock edge; the model advances on the same inputs, then outputs are settled for sampling.
    task automatic step();
        logic [31:0] ra, rb;
        ra = m_read(rs1);
        rb = use_imm ? imm : m_read(rs2);
        @(posedge clk);
        if (!stall) begin
            m_vld = issue_valid;
            if (issue_valid) begin
                m_a = ra; m_b = rb; m_ctrl = ctrl_in;
            end
        end
        if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        #1;
    endtask

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] c);
        issue_valid = 1; rs1 = s1; rs2 = s2; ctrl_in = c;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_clear();
        #2;
        checks++;
        if ({a, b, ctrl, op_valid} !== {32'd0, 32'd0, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got a=%h b=%h ctrl=%b vld=%b, want all zero", a, b, ctrl, op_valid);
        end
        repeat (3) @(posedge clk);
        #4 rst_n = 1;
        #2;
        issue(5, 7, 3'b001);
        step();
        checks++;
        if ({a, b, op_valid} !== {32'd0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_rf_zero: got a=%h b=%h vld=%b, want a=0 b=0 vld=1", a, b, op_valid);
        end
        idle();
    endtask

    task automatic test_write_read();
        wb_en = 1; wb_addr = 3; wb_data = 32'hAA;
        step();
        idle();
        issue(3, 0, 3'b010);
        step();
        checks++;
        if ({a, b, ctrl, op_valid} !== {32'hAA, 32'd0, 3'b010, 1'b1}) begin
            errors++;
            $display("FAIL write_read: got a=%h b=%h ctrl=%b vld=%b, want aa/0/010/1", a, b, ctrl, op_valid);
        end
        idle();
    endtask

    task automatic test_bypass();
        issue(4, 4, 3'b011);
        wb_en = 1; wb_addr = 4; wb_data = 32'hCC;
        step();
        checks++;
        if ({a, b} !== {32'hCC, 32'hCC}) begin
            errors++;
            $display("FAIL bypass_both: got a=%h b=%h, want cc/cc", a, b);
        end
        idle();
        wb_en = 1; wb_addr = 0; wb_data = 32'hFF;
        step();
        idle();
        issue(0, 0, 3'b100);
        step();
        checks++;
        if (a !== 32'd0) begin
            errors++;
            $display("FAIL reg0_write_ignored: got a=%h, want 0", a);
        end
        // Same-cycle write to x0 must not bypass either.
        issue(0, 4, 3'b101);
        wb_en = 1; wb_addr = 0; wb_data = 32'hFF;
        step();
        checks++;
        if ({a, b} !== {32'd0, 32'hCC}) begin
            errors++;
            $display("FAIL reg0_no_bypass: got a=%h b=%h, want 0/cc", a, b);
        end
        idle();
    endtask

    task automatic test_immediate();
        wb_en = 1; wb_addr = 2; wb_data = 32'h10;
        step();
        idle();
        issue(2, 6, 3'b110);
        use_imm = 1; imm = 32'h1234;
        wb_en = 1; wb_addr = 6; wb_data = 32'h5555;
        step();
        checks++;
        if ({a, b, ctrl} !== {32'h10, 32'h1234, 3'b110}) begin
            errors++;
            $display("FAIL immediate: got a=%h b=%h ctrl=%b, want 10/1234/110", a, b, ctrl);
        end
        idle();
    endtask

    task automatic test_stall();
        issue(2, 0, 3'b001);
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            stall = 1;
            issue(6, 2, 3'b111);
            if (i == 1) begin
                wb_en = 1; wb_addr = 2; wb_data = 32'h99;
            end
            step();
            checks++;
            if ({a, b, ctrl, op_valid} !== {32'h10, 32'd0, 3'b001, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got a=%h b=%h ctrl=%b vld=%b, want 10/0/001/1", i, a, b, ctrl, op_valid);
            end
        end
        idle();
        step();
        checks++;
        if ({a, op_valid} !== {32'h10, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: got a=%h vld=%b, want 10/0", a, op_valid);
        end
        issue(2, 2, 3'b010);
        step();
        checks++;
        if ({a, b, op_valid} !== {32'h99, 32'h99, 1'b1}) begin
            errors++;
            $display("FAIL stall_wb_landed: got a=%h b=%h vld=%b, want 99/99/1", a, b, op_valid);
        end
        idle();
    endtask

    task automatic test_async_reset();
        wb_en = 1; wb_addr = 3; wb_data = 32'hAA;
        issue(3, 3, 3'b101);
        step();
        idle();
        issue(3, 0, 3'b011);
        #2;
        rst_n = 0;
        model_clear();
        #1;
        checks++;
        if ({a, b, ctrl, op_valid} !== {32'd0, 32'd0, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_clear: got a=%h b=%h ctrl=%b vld=%b, want all zero", a, b, ctrl, op_valid);
        end
        #1 rst_n = 1;
        step();
        checks++;
        if ({a, op_valid} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset_rf: got a=%h vld=%b, want 0/1", a, op_valid);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            issue_valid = 1'($urandom_range(0, 3) != 0);
            rs1     = 5'($urandom_range(0, 7));
            rs2     = 5'($urandom_range(0, 7));
            ctrl_in = 3'($urandom);
            use_imm = 1'($urandom_range(0, 3) == 0);
            imm     = $urandom;
            stall   = 1'($urandom_range(0, 4) == 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
            checks++;
            if ({a, b, ctrl, op_valid} !== {m_a, m_b, m_ctrl, m_vld}) begin
                errors++;
                $display("FAIL random[%0d]: got a=%h b=%h ctrl=%b vld=%b, want a=%h b=%h ctrl=%b vld=%b",
                         n, a, b, ctrl, op_valid, m_a, m_b, m_ctrl, m_vld);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_immediate();
        test_stall();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Register-file-plus-issue stage directly upstream of the ALU.
- Holds the architectural register file and accepts one issue request per cycle (source register indices, ALU control code, optional immediate).
- Presents registered operands a, b and ctrl to the ALU one cycle later.
- Accepts the ALU result back through a write-back port, with same-cycle write-to-read bypass.

Parameters:
N, 32, data width of registers, operands and write-back data
A, 5, register index width; register file depth is 2**A

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  issue request present this cycle
rs1  input  A  index of operand a source register
rs2  input  A  index of operand b source register
ctrl_in  input  3  ALU control code, passed through to the ALU
use_imm  input  1  1: b is taken from imm; 0: b is taken from rs2
imm  input  N  immediate operand
stall  input  1  freeze the operand outputs
wb_en  input  1  write-back enable
wb_addr  input  A  write-back register index
wb_data  input  N  write-back data (ALU result r)
a  output  N  registered operand a to the ALU
b  output  N  registered operand b to the ALU
ctrl  output  3  registered ALU control code
op_valid  output  1  a, b and ctrl hold a valid operation

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - all 2**A registers cleared to 0;
  - a = 0, b = 0, ctrl = 3'b000, op_valid = 0.
- Reset asserted mid-operation discards any in-flight issue and write-back.
- First active clock edge is the first rising edge after rst_n deasserts.
- Register 0:
  - always reads 0;
  - wb_en with wb_addr = 0 is ignored and has no bypass.
- Write-back:
  - on a rising edge with wb_en = 1 and wb_addr != 0, reg[wb_addr] <= wb_data;
  - independent of stall and issue_valid.
- Source read value, for src = rs1 or rs2:
  - 0 if src = 0;
  - else wb_data if wb_en = 1 and wb_addr = src (bypass: same-edge write is visible);
  - else reg[src].
- Issue (rising edge, stall = 0):
  - op_valid <= issue_valid.
  - If issue_valid = 1:
    - a <= read(rs1);
    - b <= (use_imm ? imm : read(rs2));
    - ctrl <= ctrl_in.
  - If issue_valid = 0: a, b and ctrl hold their previous values; only op_valid drops.
- Stall (rising edge, stall = 1):
  - a, b, ctrl and op_valid all hold;
  - issue inputs are ignored and the request is lost; the upstream must re-present it;
  - held operands are NOT refreshed by write-backs during the stall. The hazard unit must not stall a consumer of a pending write.
- Latency: request presented before edge k appears on a/b/ctrl/op_valid after edge k. One operation per cycle; no internal buffering.
- Simultaneous cases:
  - rs1 = rs2 = wb_addr with wb_en: both operands bypass;
  - use_imm = 1 ignores rs2 entirely, including its bypass.
- Widths: no arithmetic in this block; imm is used as-is, with no sign extension here.
- All outputs are driven from flops only; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n = 0, then release. Check a = 0, b = 0, ctrl = 000, op_valid = 0. Issue rs1 = 5, rs2 = 7 -> a = 0, b = 0.
- Write then read:
  - wb_en, wb_addr = 3, wb_data = 32'hAA on cycle 1;
  - issue rs1 = 3, rs2 = 0, ctrl_in = 010 on cycle 2;
  - after edge: a = 32'hAA, b = 0, ctrl = 010, op_valid = 1.
- Bypass:
  - same cycle: wb_en, wb_addr = 4, wb_data = 32'hCC, issue rs1 = 4, rs2 = 4 -> a = b = 32'hCC;
  - write wb_addr = 0, data 32'hFF, then read rs1 = 0 -> a = 0.
- Immediate:
  - reg[2] = 32'h10; issue rs1 = 2, use_imm = 1, imm = 32'h1234, with same-cycle wb to rs2 = 6 -> a = 32'h10, b = 32'h1234.
- Stall:
  - issue op X (a = 32'h10), then stall = 1 for 3 cycles while issuing op Y and writing reg[2] = 32'h99;
  - outputs stay at X with op_valid = 1 throughout;
  - after release with issue_valid = 0: op_valid = 0, a still 32'h10, and reg[2] reads 32'h99 on the next issue.
- Async reset mid-run:
  - with op_valid = 1 and reg[3] = 32'hAA, pulse rst_n low between clock edges;
  - outputs clear immediately without a clock edge;
  - a subsequent read of rs1 = 3 returns 0.
